// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared definitions for the count sequence monitor.
//   mon_state_t   - monitor state encoding (IDLE, SYNC, LOCKED, FAULT)
//   DEF_WIDTH     - default width of the monitored count
//   DEF_LOCK_CNT  - default number of good increments needed to lock
//   DEF_ERRW      - default width of the saturating error/wrap counters
package count_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } mon_state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 2;
  localparam int DEF_ERRW     = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset, clears value
//   clr    - synchronous clear, lower priority than reset
//   inc    - increment request; ignored once value is all-ones
//   value  - current count (ERRW bits)
module sat_counter #(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            inc,
  output logic [ERRW-1:0] value
);

  logic [ERRW-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_reg <= '0;
    end else if (clr) begin
      value_reg <= '0;
    end else if (inc && (value_reg != '1)) begin
      value_reg <= value_reg + ERRW'(1);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks that a sampled count follows a modulo-2^WIDTH
// increment-by-one sequence. Locks onto the running count, then flags
// skips/stalls as errors, restarts at 0 as restarts, and all-ones->0 as wraps.
// Ports:
//   clk           - system clock, rising edge
//   reset         - synchronous active-low reset
//   en            - sample strobe; q_in is evaluated only when en=1
//   q_in          - count value under observation (WIDTH bits)
//   clr           - synchronous clear of counters and state (below reset)
//   locked        - high while LOCKED
//   err_pulse     - one-cycle pulse per detected sequence error
//   restart_pulse - one-cycle pulse when the count restarts at 0 while LOCKED
//   wrap_pulse    - one-cycle pulse on a LOCKED all-ones -> 0 transition
//   expected      - value predicted for the next sample
//   err_count     - saturating error counter (ERRW bits)
//   wrap_count    - saturating wrap counter (ERRW bits)
//   fault         - high while in FAULT (only with the sticky build)
// Build option: define COUNT_SEQ_MONITOR_STICKY_FAULT_EN to make FAULT sticky
// until clr or reset and to add the fault output.
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERRW     = DEF_ERRW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             restart_pulse,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] expected,
  output logic [ERRW-1:0]  err_count,
  output logic [ERRW-1:0]  wrap_count
`ifdef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
  ,
  output logic             fault
`endif
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  mon_state_t       state_reg, state_next;
  logic [WIDTH-1:0] expected_reg, expected_next;
  logic [3:0]       good_reg, good_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             restart_pulse_reg, restart_pulse_next;
  logic             wrap_pulse_reg, wrap_pulse_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      expected_reg      <= '0;
      good_reg          <= '0;
      err_pulse_reg     <= 1'b0;
      restart_pulse_reg <= 1'b0;
      wrap_pulse_reg    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      expected_reg      <= expected_next;
      good_reg          <= good_next;
      err_pulse_reg     <= err_pulse_next;
      restart_pulse_reg <= restart_pulse_next;
      wrap_pulse_reg    <= wrap_pulse_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    expected_next      = expected_reg;
    good_next          = good_reg;
    err_pulse_next     = 1'b0;
    restart_pulse_next = 1'b0;
    wrap_pulse_next    = 1'b0;

    if (clr) begin
      // clr wins over a sample arriving in the same cycle
      state_next = IDLE;
      good_next  = '0;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          expected_next = q_in + WIDTH'(1);
          good_next     = '0;
          state_next    = SYNC;
        end
        SYNC: begin
          if (q_in == expected_reg) begin
            expected_next = expected_reg + WIDTH'(1);
            good_next     = good_reg + 4'd1;
            if ((good_reg + 4'd1) == LOCK_TGT) begin
              state_next = LOCKED;
            end
          end else begin
            // no error reporting while still hunting for the sequence
            expected_next = q_in + WIDTH'(1);
            good_next     = '0;
          end
        end
        LOCKED: begin
          if (q_in == expected_reg) begin
            expected_next = expected_reg + WIDTH'(1);
            // a correct 0 sample can only follow all-ones
            if (q_in == '0) begin
              wrap_pulse_next = 1'b1;
            end
          end else if (q_in == '0) begin
            // counter was reset underneath us: follow it, not an error
            restart_pulse_next = 1'b1;
            expected_next      = WIDTH'(1);
          end else begin
            err_pulse_next = 1'b1;
            state_next     = FAULT;
          end
        end
        FAULT: begin
`ifdef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
          // parked until clr or reset
          state_next = FAULT;
`else
          expected_next = q_in + WIDTH'(1);
          good_next     = '0;
          state_next    = SYNC;
`endif
        end
      endcase
    end
  end

  // index 0 counts errors, index 1 counts wraps
  logic [1:0]      inc_vec;
  logic [ERRW-1:0] cnt_vec [2];

  // incrementing from the next-state pulses keeps each counter in step
  // with its registered pulse
  assign inc_vec = {wrap_pulse_next, err_pulse_next};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .ERRW(ERRW)
      ) u_sat_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .inc  (inc_vec[gi]),
        .value(cnt_vec[gi])
      );
    end
  endgenerate

  assign locked        = (state_reg == LOCKED);
  assign err_pulse     = err_pulse_reg;
  assign restart_pulse = restart_pulse_reg;
  assign wrap_pulse    = wrap_pulse_reg;
  assign expected      = expected_reg;
  assign err_count     = cnt_vec[0];
  assign wrap_count    = cnt_vec[1];
`ifdef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
  assign fault         = (state_reg == FAULT);
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: self-checking bench for count_seq_monitor.
// Directed scenarios followed by randomized stimulus; every cycle is compared
// against a behavioural model of the monitoring rules.
// Honours COUNT_SEQ_MONITOR_STICKY_FAULT_EN when the build defines it.
module tb_count_seq_monitor;

  localparam int W    = 4;
  localparam int LC   = 2;
  localparam int EW   = 8;
  localparam int MODV = 1 << W;
  localparam int CMAX = (1 << EW) - 1;

  // model phases
  localparam int P_IDLE  = 0;
  localparam int P_HUNT  = 1;
  localparam int P_TRACK = 2;
  localparam int P_FAULT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  q_in = '0;
  logic          locked;
  logic          err_pulse;
  logic          restart_pulse;
  logic          wrap_pulse;
  logic [W-1:0]  expected;
  logic [EW-1:0] err_count;
  logic [EW-1:0] wrap_count;
`ifdef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
  logic          fault;
`endif

  count_seq_monitor #(
    .WIDTH(W),
    .LOCK_CNT(LC),
    .ERRW(EW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .q_in         (q_in),
    .clr          (clr),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .restart_pulse(restart_pulse),
    .wrap_pulse   (wrap_pulse),
    .expected     (expected),
    .err_count    (err_count),
    .wrap_count   (wrap_count)
`ifdef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
    ,
    .fault        (fault)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // behavioural model state
  int m_phase = P_IDLE;
  int m_exp   = 0;
  int m_run   = 0;
  int m_err   = 0;
  int m_wrap  = 0;
  bit m_errp  = 0;
  bit m_rstp  = 0;
  bit m_wrapp = 0;

  task automatic model_step(input bit r, input bit c, input bit e, input int q);
    m_errp  = 0;
    m_rstp  = 0;
    m_wrapp = 0;
    if (!r) begin
      m_phase = P_IDLE; m_exp = 0; m_run = 0; m_err = 0; m_wrap = 0;
    end else if (c) begin
      m_phase = P_IDLE; m_run = 0; m_err = 0; m_wrap = 0;
    end else if (e) begin
      case (m_phase)
        P_IDLE: begin
          m_exp = (q + 1) % MODV; m_run = 0; m_phase = P_HUNT;
        end
        P_HUNT: begin
          if (q == m_exp) begin
            m_run++;
            if (m_run >= LC) m_phase = P_TRACK;
          end else begin
            m_run = 0;
          end
          m_exp = (q + 1) % MODV;
        end
        P_TRACK: begin
          if (q == m_exp) begin
            m_exp = (q + 1) % MODV;
            if (q == 0) begin
              m_wrapp = 1;
              if (m_wrap < CMAX) m_wrap++;
            end
          end else if (q == 0) begin
            m_rstp = 1;
            m_exp  = 1;
          end else begin
            m_errp = 1;
            if (m_err < CMAX) m_err++;
            m_phase = P_FAULT;
          end
        end
        default: begin
`ifndef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
          m_exp = (q + 1) % MODV; m_run = 0; m_phase = P_HUNT;
`endif
        end
      endcase
    end
  endtask

  // drive one cycle, then compare every output with the model
  task automatic step(input bit r, input bit c, input bit e, input int q);
    logic [31:0] qv;
    qv    = q;
    reset = r;
    clr   = c;
    en    = e;
    q_in  = qv[W-1:0];
    @(posedge clk);
    #1;
    model_step(r, c, e, q);
    check("locked", locked, (m_phase == P_TRACK));
    check("err_pulse", err_pulse, m_errp);
    check("restart_pulse", restart_pulse, m_rstp);
    check("wrap_pulse", wrap_pulse, m_wrapp);
    check("expected", expected, m_exp);
    check("err_count", err_count, m_err);
    check("wrap_count", wrap_count, m_wrap);
`ifdef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
    check("fault", fault, (m_phase == P_FAULT));
`endif
  endtask

  function automatic int bad_val(input int e);
    int b;
    b = (e + 2) % MODV;
    return (b == 0) ? 3 : b;
  endfunction

  initial begin
    int wp;
    int ep;
    int ctr;
    int k;
    int q;
    bit r;
    bit c;
    bit e;

    // reset held for three cycles
    repeat (3) step(0, 0, 0, 0);
    check("rst_locked", locked, 0);
    check("rst_expected", expected, 0);
    check("rst_err_count", err_count, 0);

    // lock onto 0,1,2
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 2);
    check("lock_after_2", locked, 1);
    check("lock_expected", expected, 3);
    check("lock_err_count", err_count, 0);

    // run through all-ones to 0
    wp = 0;
    ep = 0;
    for (int v = 3; v <= MODV; v++) begin
      step(1, 0, 1, v % MODV);
      wp += int'(wrap_pulse);
      ep += int'(err_pulse);
    end
    check("wrap_pulses", wp, 1);
    check("wrap_count_1", wrap_count, 1);
    check("no_err_on_wrap", ep, 0);

    // skip 3,4,6
    step(1, 0, 1, 1);
    step(1, 0, 1, 2);
    step(1, 0, 1, 3);
    step(1, 0, 1, 4);
    step(1, 0, 1, 6);
    check("skip_err_pulse", err_pulse, 1);
    check("skip_err_count", err_count, 1);
    check("skip_locked", locked, 0);

`ifdef COUNT_SEQ_MONITOR_STICKY_FAULT_EN
    for (int v = 7; v < 27; v++) begin
      step(1, 0, 1, v % MODV);
      check("sticky_fault", fault, 1);
      check("sticky_locked", locked, 0);
    end
    check("sticky_err_count", err_count, 1);
    step(1, 1, 0, 0);
    check("sticky_clr_fault", fault, 0);
    check("sticky_clr_locked", locked, 0);
    check("sticky_clr_err", err_count, 0);
`else
    // relock on 9
    step(1, 0, 1, 7);
    step(1, 0, 1, 8);
    check("relock_at_8", locked, 0);
    step(1, 0, 1, 9);
    check("relock_at_9", locked, 1);

    // counter restart while locked
    step(1, 0, 1, 10);
    step(1, 0, 1, 0);
    check("restart_pulse", restart_pulse, 1);
    check("restart_no_err", err_pulse, 0);
    check("restart_expected", expected, 1);
    check("restart_locked", locked, 1);

    // force 300 errors: bad sample, resync on 5, lock on 6,7
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 1, bad_val(m_exp));
      step(1, 0, 1, 5);
      step(1, 0, 1, 6);
      step(1, 0, 1, 7);
    end
    check("err_saturated", err_count, CMAX);

    // clr beats a same-cycle sample
    step(1, 1, 1, 9);
    check("clr_err_count", err_count, 0);
    check("clr_wrap_count", wrap_count, 0);
    check("clr_locked", locked, 0);
    step(1, 0, 1, 4);
    check("clr_idle_load", expected, 5);
`endif

    // randomized phase
    ctr = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom % 200) != 0;
      c = ($urandom % 100) == 0;
      e = ($urandom % 4) != 0;
      k = $urandom % 100;
      if (k < 4)       q = (ctr + 2) % MODV;
      else if (k < 7)  q = ctr;
      else if (k < 10) q = 0;
      else if (k < 12) q = $urandom % MODV;
      else             q = (ctr + 1) % MODV;
      step(r, c, e, q);
      if (e) ctr = q;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
